booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//   Parametrised sequential signed Booth multiplier: controller + datapath in one block with valid/ready on both sides.
//   Replaces the fixed 5-bit datapath/external-controller pair; operands load in parallel, product returns in one beat.
//   Sits between the operand source and the result consumer in the arithmetic unit; one multiplication in flight.
// PARAMETERS
//   W        8   operand width (two's complement), W >= 2; product is 2*W bits
//   CNT_W    $clog2(W+1)   iteration counter width (derived, do not override)
// PORTS
//   clk        in   1     single clock, all state on rising edge
//   rst        in   1     asynchronous reset, active-low (0 = reset)
//   in_valid   in   1     operand pair valid
//   in_ready   out  1     block can accept operands (high only in IDLE)
//   mcand      in   W     multiplicand M (signed)
//   mplier     in   W     multiplier Q (signed)
//   out_valid  out  1     product valid; held until accepted
//   out_ready  in   1     consumer accepts product
//   product    out  2W    signed M*Q, stable while out_valid
//   busy       out  1     high in CALC or DONE
// BEHAVIOUR
//   - Reset (rst=0, any state, any time): state=IDLE, in_ready=1 after release, out_valid=0, busy=0,
//     product=0, A/Q/q_m1/counter=0. In-flight operation is discarded, no output produced.
//   - FSM: IDLE -> CALC on in_valid&&in_ready; CALC -> DONE on edge completing last iteration;
//     DONE -> IDLE on out_valid&&out_ready; otherwise hold. No other transitions.
//   - Load edge (IDLE accept): M<=mcand, Q<=mplier, A<=0 (W+1 bits), q_m1<=0, cnt<=W.
//   - Radix-2 iteration (one per clock in CALC): on {Q[0],q_m1}: 01 A<=A+sext(M), 10 A<=A-sext(M), 00/11 no-op;
//     then arithmetic shift right of {A,Q,q_m1} by 1; cnt<=cnt-1. Last iteration is when cnt==1.
//   - A is W+1 bits so M=-2^(W-1) never overflows; product={A[W-1:0],Q} (exact, incl. (-2^(W-1))^2).
//   - Latency: out_valid rises W edges after the accepting edge; product registered at that same edge.
//   - Throughput: new operands accepted no earlier than the edge after the product handshake (W+2 cycles min).
//   - in_valid while not IDLE: ignored, operands not sampled; mcand/mplier may change freely during CALC.
//   - Backpressure: out_valid=1 && out_ready=0 holds product and state indefinitely.
//   - out_ready while out_valid=0: ignored. in_valid and out_ready both high in DONE: only output handshake happens.
// CONFIGURATION
//   BOOTH_RADIX4_EN defined: radix-4 (modified Booth) recoding. Requires W even (elaboration error otherwise).
//     A widened to W+2 bits, cnt<=W/2; per clock examine {Q[1],Q[0],q_m1}:
//     000/111 +0, 001/010 +M, 011 +2M, 100 -2M, 101/110 -M; then arithmetic shift right by 2.
//     Latency W/2 edges after accept; product={A[W-1:0],Q}. Handshake/reset identical.
//   Not defined: radix-2 as above, latency W; any W >= 2 legal.
// TESTING (W=8 unless stated)
//   1. Reset low mid-run, release, in_valid with 3,5 -> in_ready=1 at accept, out_valid 8 edges later, product=15.
//   2. -128 * -128 -> product=16384 (0x4000); 127 * -1 -> -127 (0xFF81); -128 * 127 -> -16256 (0xC080).
//   3. out_ready=0 for 20 cycles after out_valid -> product/out_valid stable, in_ready=0, busy=1; then accept -> IDLE next edge.
//   4. in_valid pulsed with 9,9 during CALC of 2*6 -> ignored; result 12; next accepted pair computed correctly.
//   5. rst=0 at iteration 4 of 100*100 -> out_valid=0, product=0 immediately (async); after release no stale output.
//   6. Random 10k signed pairs, W=8 and W=13 radix-2, W=16 with BOOTH_RADIX4_EN (latency 8) -> matches $signed model.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier with valid/ready handshakes on operands and product.
// Radix-2 recoding by default (W iterations). Define BOOTH_RADIX4_EN for modified Booth
// radix-4 recoding (W/2 iterations, W must be even).
module booth_mult_seq #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     mcand,
    input  logic [W-1:0]     mplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(W + 1);

`ifdef BOOTH_RADIX4_EN
    // Two guard bits so that +/-2M never overflows the partial product.
    localparam int unsigned AW    = W + 2;
    localparam int unsigned STEPS = W / 2;
    localparam int unsigned SHIFT = 2;

    if ((W % 2) != 0) begin : g_w_odd
        $error("booth_mult_seq: radix-4 recoding requires an even W");
    end
`else
    // One guard bit keeps M = -2^(W-1) exact.
    localparam int unsigned AW    = W + 1;
    localparam int unsigned STEPS = W;
    localparam int unsigned SHIFT = 1;
`endif

    if (W < 2) begin : g_w_small
        $error("booth_mult_seq: W must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       m_q;
    logic [AW-1:0]      a_q;
    logic [W-1:0]       q_q;
    logic               qm1_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*W-1:0]     product_q;

    logic               accept;
    logic               last_iter;
    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic signed [AW+W:0] cat_sh;
    logic [AW-1:0]      a_sh;
    logic [W-1:0]       q_sh;
    logic               qm1_sh;

    assign accept    = (state_q == StIdle) && in_valid;
    assign last_iter = (state_q == StCalc) && (cnt_q == CNT_W'(1));

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StCalc) || (state_q == StDone);
    assign product   = product_q;

    // Booth recoding of the low multiplier bits into the partial-product addend.
    always_comb begin
        m_ext  = {{(AW - W){m_q[W-1]}}, m_q};
        addend = '0;
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
`else
        case ({q_q[0], qm1_q})
            2'b01:   addend = m_ext;
            2'b10:   addend = -m_ext;
            default: addend = '0;
        endcase
`endif
        sum    = a_q + addend;
        // Arithmetic shift of the whole {A,Q,q_m1} chain.
        cat_sh = $signed({sum, q_q, qm1_q}) >>> SHIFT;
        a_sh   = cat_sh[AW+W:W+1];
        q_sh   = cat_sh[W:1];
        qm1_sh = cat_sh[0];
    end

    // Next-state logic for the handshake controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last_iter) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand load, one Booth step per CALC cycle, product capture on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            m_q   <= mcand;
            a_q   <= '0;
            q_q   <= mplier;
            qm1_q <= 1'b0;
            cnt_q <= CNT_W'(STEPS);
        end else if (state_q == StCalc) begin
            a_q   <= a_sh;
            q_q   <= q_sh;
            qm1_q <= qm1_sh;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter) begin
                product_q <= {a_sh[W-1:0], q_sh};
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at W=8: vector table plus handshake/reset corner sequences.
module tb_booth_mult_seq;

    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT = W / 2;
`else
    localparam int LAT = W;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    booth_mult_seq #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mcand    (mcand),
        .mplier   (mplier),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Present operands at a negedge, return at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
        mcand    = a;
        mplier   = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take_result(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp);
        int n;
        launch(a, b);
        wait_done(n);
        chk({name, "_lat"}, n, LAT);
        chk({name, "_prod"}, {16'd0, product}, {16'd0, exp});
        take_result(name);
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        int   n;
        int   errs;
        logic [2*W-1:0] held;
        logic signed [W-1:0]   ra, rb;
        logic signed [2*W-1:0] rexp;

        vecs[0]  = '{8'd3,    8'd5,    16'd15};
        vecs[1]  = '{8'h80,   8'h80,   16'h4000};  // -128 * -128
        vecs[2]  = '{8'd127,  8'hFF,   16'hFF81};  // 127 * -1
        vecs[3]  = '{8'h80,   8'd127,  16'hC080};  // -128 * 127
        vecs[4]  = '{8'd0,    8'd0,    16'h0000};
        vecs[5]  = '{8'hFF,   8'hFF,   16'h0001};  // -1 * -1
        vecs[6]  = '{8'd1,    8'h80,   16'hFF80};  // 1 * -128
        vecs[7]  = '{8'd2,    8'd6,    16'd12};
        vecs[8]  = '{8'd100,  8'd100,  16'd10000};
        vecs[9]  = '{8'hF9,   8'd9,    16'hFFC1};  // -7 * 9
        vecs[10] = '{8'd127,  8'd127,  16'h3F01};
        vecs[11] = '{8'h80,   8'd1,    16'hFF80};  // -128 * 1

        // Reset state.
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_product", {16'd0, product}, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Async reset in the middle of 100*100.
        launch(8'd100, 8'd100);
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        errs = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) errs++;
        end
        chk("mid_rst_no_stale", errs, 0);
        run_vec("after_rst", 8'd3, 8'd5, 16'd15);

        // Async reset while a product is being held.
        launch(8'd100, 8'd100);
        wait_done(n);
        chk("done_rst_prod_before", {16'd0, product}, 32'd10000);
        #2 rst = 1'b0;
        #1;
        chk("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("done_rst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Backpressure: product held for 20 cycles.
        launch(8'd7, 8'hFD);
        wait_done(n);
        chk("bp_lat", n, LAT);
        held = product;
        chk("bp_prod", {16'd0, held}, 32'h0000FFEB);
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || in_ready || !busy || product !== held) errs++;
        end
        chk("bp_stable", errs, 0);
        take_result("bp");

        // in_valid pulsed during CALC must be ignored.
        launch(8'd2, 8'd6);
        repeat (2) @(negedge clk);
        chk("calc_in_ready", {31'd0, in_ready}, 32'd0);
        mcand    = 8'd9;
        mplier   = 8'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mcand    = 8'hAA;
        mplier   = 8'h55;
        wait_done(n);
        chk("ign_lat", n + 3, LAT);
        chk("ign_prod", {16'd0, product}, 32'd12);
        take_result("ign");
        run_vec("after_ign", 8'd9, 8'd9, 16'd81);

        // in_valid and out_ready together in DONE: only the output handshake.
        launch(8'd4, 8'd4);
        wait_done(n);
        chk("both_prod", {16'd0, product}, 32'd16);
        mcand     = 8'd4;
        mplier    = 8'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("both_idle", {30'd0, out_valid, in_ready}, 32'b01);
        mcand = 8'd6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("both_accepted", {31'd0, in_ready}, 32'd0);
        wait_done(n);
        chk("both_lat", n, LAT);
        chk("both_next_prod", {16'd0, product}, 32'd30);
        take_result("both");

        // Random signed pairs against a signed-multiply model.
        for (int i = 0; i < 100; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rexp = ra * rb;
            run_vec($sformatf("rnd%0d", i), ra, rb, rexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
